hp_div_seq: RTL and testbench
=============================

# hp_div_seq

Sequential IEEE-style floating-point divider for the bfloat16-class (NEXP/NSIG-parameterised) datapath; the inverse companion to the combinational multiplier in the float processing unit. It accepts one operand pair per start pulse and produces `q = a / b` through a restoring radix-2 iteration. It reports round-to-nearest-even results with the unit's standard class flags and exception flags. It sits beside the multiplier behind the FPU operation dispatcher, which holds operands stable only for the start cycle.

## Interface
- NEXP, 8, exponent width; BIAS = 2^(NEXP-1)-1
- NSIG, 7, stored fraction width; iteration count NITER = NSIG+3
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset (one clock; asynchronous assert, active-low, fixed)
- start  in  1  request; sampled only in IDLE
- a  in  NEXP+NSIG+1  dividend, captured on the start edge
- b  in  NEXP+NSIG+1  divisor, captured on the start edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; q/flags valid from this cycle
- q  out  NEXP+NSIG+1  registered quotient; held until the next done
- bfFlags  out  6  result class: [0]NORMAL [1]SUBNORMAL [2]ZERO [3]INFINITY [4]QNAN [5]SNAN (never set)
- exception  out  5  [0]INVALID [1]DIVIDEBYZERO [2]OVERFLOW [3]UNDERFLOW [4]INEXACT

## Operation
- States: IDLE -> PREP -> DIV (NITER cycles) -> RND -> DONE -> IDLE. Special operands go PREP -> DONE.
- PREP classifies both operands and resolves specials, in this priority order:
  - Either operand is sNaN -> 0x7FC0-class canonical qNaN (sign 0), INVALID.
  - Either operand is qNaN -> canonical qNaN, no exception.
  - inf/inf or 0/0 -> canonical qNaN, INVALID.
  - inf/x -> signed inf.
  - x/inf -> signed zero.
  - finite nonzero / 0 -> signed inf, DIVIDEBYZERO.
  - 0/x -> signed zero.
- Sign of every non-NaN result = a.sign ^ b.sign.
- PREP, finite case:
  - Subnormal significands are normalised by a leading-zero shift. Effective exponent is 1 - shift.
  - Exponent register is signed, NEXP+2 bits: e = ea - eb + BIAS.
  - If ma < mb, then ma <<= 1 and e -= 1. This leaves the quotient in [1,2).
- DIV: one quotient bit per cycle, MSB first. NITER bits = 1 integer + NSIG fraction + guard + round. Sticky = (final remainder != 0).
- RND: round-to-nearest-even on {guard, round|sticky}. A significand carry-out increments e.
  - e >= 2^NEXP-1 -> signed inf, OVERFLOW|INEXACT.
  - e < 1 -> right-shift the unrounded quotient by 1-e, OR-ing lost bits into sticky, then round.
    - If shift > NSIG+2 -> signed zero, UNDERFLOW|INEXACT.
    - If rounding carries into the minimum normal -> NORMAL class with exponent 1.
  - UNDERFLOW is raised only when the result is tiny and inexact.
  - INEXACT = guard | round | sticky.
- bfFlags has exactly one bit set in DONE.

## Timing
- Start is sampled at edge 0. PREP occupies cycle 1, DIV cycles 2..NITER+1, RND cycle NITER+2, DONE cycle NITER+3.
- Finite latency is 13 cycles at default parameters; special-case latency is 2 cycles (done in cycle 2).
- q, bfFlags and exception are registered on entry to DONE and stay stable until the next DONE.
- start while busy=1 (including the DONE cycle) is ignored, not queued. The earliest next accept is the first IDLE cycle after done.
- Reset values: state IDLE, busy 0, done 0, q 0, bfFlags 0, exception 0.
- rst_n asserted mid-operation aborts immediately. No done is produced and outputs return to their reset values.

## Configuration
- HP_DIV_SUBNORMAL_EN defined: full subnormal input normalisation and gradual-underflow output, as above.
- HP_DIV_SUBNORMAL_EN undefined:
  - Subnormal inputs are treated as signed zero (classified ZERO, so x/subnormal -> DIVIDEBYZERO).
  - Any result with e < 1 is flushed to signed zero with ZERO class and UNDERFLOW|INEXACT.
  - The PREP leading-zero shifter and the denormalising shifter are not built.

## Test plan
- 0x40C0 / 0x4000 (6/2) -> q=0x4040, bfFlags NORMAL, exception 0, done exactly 13 cycles after the start edge.
- 0x3F80 / 0x4040 (1/3) -> q=0x3EAB, NORMAL, exception INEXACT only.
- Special operands:
  - 0x3F80 / 0x0000 -> q=0x7F80, INFINITY, DIVIDEBYZERO, done at cycle 2.
  - 0x0000 / 0x8000 -> q=0x7FC0, QNAN, INVALID.
  - 0x7F81 (sNaN) / 0x3F80 -> q=0x7FC0, INVALID.
- 0x7F7F / 0x3F00 -> q=0x7F80, INFINITY, OVERFLOW|INEXACT.
- 0x0080 / 0x4000:
  - With macro -> q=0x0040, SUBNORMAL, exception 0.
  - Without macro -> q=0x0000, ZERO, UNDERFLOW|INEXACT.
- Control cases:
  - start pulsed again during DIV -> ignored; single done.
  - rst_n low at cycle 5 -> no done, all outputs 0.
  - Back-to-back requests issued in the first IDLE cycle each complete correctly.

Source files
------------

// File: rtl/hp_div_seq_if.sv
// Operand/result bundle between the FPU operation dispatcher (master) and
// the sequential floating-point divider hp_div_seq (slave).
interface hp_div_seq_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  localparam int W = NEXP + NSIG + 1;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [5:0]   bfFlags;
  logic [4:0]   exception;

  modport master (
    output start, a, b,
    input  busy, done, q, bfFlags, exception
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, bfFlags, exception
  );
endinterface

// File: rtl/hp_div_seq.sv
// hp_div_seq: sequential floating-point divider q = a / b.
// Restoring radix-2 iteration producing 1 integer + NSIG fraction + guard +
// round bits, then round-to-nearest-even with class and exception flags.
// Optional feature macro HP_DIV_SUBNORMAL_EN: when defined, subnormal inputs
// are normalised and tiny results underflow gradually; when undefined,
// subnormal inputs read as zero and tiny results flush to signed zero.
module hp_div_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  hp_div_seq_if.slave bus
);

  localparam int W     = NEXP + NSIG + 1;
  localparam int NITER = NSIG + 3;
  localparam int EW    = NEXP + 2;   // signed working exponent
  localparam int MW    = NSIG + 1;   // significand including hidden bit
  localparam int RW    = NSIG + 3;   // partial remainder
  localparam int CW    = $clog2(NITER);

  localparam logic signed [EW-1:0] BIAS  = EW'(2**(NEXP-1) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'(2**NEXP - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
`ifdef HP_DIV_SUBNORMAL_EN
  localparam logic signed [EW-1:0] SH_MAX = EW'(NSIG + 2);
`endif

  localparam logic [W-1:0] QNAN_Q = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  localparam logic [5:0] F_NORMAL = 6'b000001;
  localparam logic [5:0] F_SUBN   = 6'b000010;
  localparam logic [5:0] F_ZERO   = 6'b000100;
  localparam logic [5:0] F_INF    = 6'b001000;
  localparam logic [5:0] F_QNAN   = 6'b010000;

  localparam logic [4:0] X_NONE = 5'b00000;
  localparam logic [4:0] X_INV  = 5'b00001;
  localparam logic [4:0] X_DBZ  = 5'b00010;
  localparam logic [4:0] X_OVF  = 5'b00100;
  localparam logic [4:0] X_UNF  = 5'b01000;
  localparam logic [4:0] X_INX  = 5'b10000;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_RND, S_DONE} state_t;

  state_t                 state_q;
  logic                   busy_q, done_q;
  logic [W-1:0]           q_q;
  logic [5:0]             flags_q;
  logic [4:0]             exc_q;
  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic signed [EW-1:0]   e_q;
  logic [MW-1:0]          mb_q;
  logic [RW-1:0]          rem_q;
  logic [NITER-1:0]       quo_q;
  logic [CW-1:0]          cnt_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.q         = q_q;
  assign bus.bfFlags   = flags_q;
  assign bus.exception = exc_q;

  // Operand fields and classification of the captured operands
  logic                a_sign, b_sign, res_sign;
  logic [NEXP-1:0]     a_exp, b_exp;
  logic [NSIG-1:0]     a_frac, b_frac;
  logic                a_nan, b_nan, a_snan, b_snan, a_qnan, b_qnan;
  logic                a_inf, b_inf, a_zero, b_zero;

  assign a_sign   = a_q[W-1];
  assign b_sign   = b_q[W-1];
  assign res_sign = a_sign ^ b_sign;
  assign a_exp    = a_q[W-2:NSIG];
  assign b_exp    = b_q[W-2:NSIG];
  assign a_frac   = a_q[NSIG-1:0];
  assign b_frac   = b_q[NSIG-1:0];
  assign a_nan    = (&a_exp) && (a_frac != '0);
  assign b_nan    = (&b_exp) && (b_frac != '0);
  assign a_snan   = a_nan && !a_frac[NSIG-1];
  assign b_snan   = b_nan && !b_frac[NSIG-1];
  assign a_qnan   = a_nan && a_frac[NSIG-1];
  assign b_qnan   = b_nan && b_frac[NSIG-1];
  assign a_inf    = (&a_exp) && (a_frac == '0);
  assign b_inf    = (&b_exp) && (b_frac == '0);
`ifdef HP_DIV_SUBNORMAL_EN
  assign a_zero   = (a_exp == '0) && (a_frac == '0);
  assign b_zero   = (b_exp == '0) && (b_frac == '0);
`else
  // Subnormal inputs are read as zero.
  assign a_zero   = (a_exp == '0);
  assign b_zero   = (b_exp == '0);
`endif

  // Special-operand resolution, highest priority first
  logic         spec_hit;
  logic [W-1:0] spec_q;
  logic [5:0]   spec_flags;
  logic [4:0]   spec_exc;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    spec_hit   = 1'b1;
    spec_q     = QNAN_Q;
    spec_flags = F_QNAN;
    spec_exc   = X_NONE;
    if (a_snan || b_snan) begin
      spec_exc = X_INV;
    end else if (a_qnan || b_qnan) begin
      spec_exc = X_NONE;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_exc = X_INV;
    end else if (a_inf) begin
      spec_q     = {res_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      spec_flags = F_INF;
    end else if (b_inf) begin
      spec_q     = {res_sign, {(W-1){1'b0}}};
      spec_flags = F_ZERO;
    end else if (b_zero) begin
      spec_q     = {res_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      spec_flags = F_INF;
      spec_exc   = X_DBZ;
    end else if (a_zero) begin
      spec_q     = {res_sign, {(W-1){1'b0}}};
      spec_flags = F_ZERO;
    end else begin
      spec_hit = 1'b0;
    end
  end

`ifdef HP_DIV_SUBNORMAL_EN
  // Left shift that brings the leading one of a subnormal fraction to the
  // hidden-bit position.
  function automatic logic signed [EW-1:0] lz_shift(input logic [NSIG-1:0] f);
    lz_shift = '0;
    for (int i = 0; i < NSIG; i++) begin
      if (f[i]) lz_shift = EW'(NSIG - i);
    end
  endfunction
`endif

  // Finite-operand preparation: significands, exponent and initial remainder
  logic [MW-1:0]        ma_n, mb_n;
  logic signed [EW-1:0] ea_n, eb_n, e_raw, e_init;
  logic [RW-1:0]        rem_init;

  always_comb begin
    ma_n = {1'b1, a_frac};
    mb_n = {1'b1, b_frac};
    ea_n = {2'b00, a_exp};
    eb_n = {2'b00, b_exp};
`ifdef HP_DIV_SUBNORMAL_EN
    if (a_exp == '0) begin
      ma_n = {1'b0, a_frac} << lz_shift(a_frac);
      ea_n = E_ONE - lz_shift(a_frac);
    end
    if (b_exp == '0) begin
      mb_n = {1'b0, b_frac} << lz_shift(b_frac);
      eb_n = E_ONE - lz_shift(b_frac);
    end
`endif
    e_raw = ea_n - eb_n + BIAS;
    // Pre-scaling the dividend keeps the quotient in [1,2).
    if (ma_n < mb_n) begin
      rem_init = {1'b0, ma_n, 1'b0};
      e_init   = e_raw - E_ONE;
    end else begin
      rem_init = {2'b00, ma_n};
      e_init   = e_raw;
    end
  end

  // One restoring-division step
  logic [RW-1:0] mb_ext, rem_div_d;
  logic          div_bit;

  always_comb begin
    mb_ext    = {2'b00, mb_q};
    div_bit   = (rem_q >= mb_ext);
    rem_div_d = (div_bit ? (rem_q - mb_ext) : rem_q) << 1;
  end

  // Round-to-nearest-even, tininess handling and result classification
  logic [NITER-1:0]     rnd_v;
  logic                 rnd_s, g_bit, r_bit, inexact, up, carry, hidden, tiny;
  logic [MW-1:0]        mant, mant_n;
  logic [MW:0]          mant_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         rnd_q;
  logic [5:0]           rnd_flags;
  logic [4:0]           rnd_exc;
`ifdef HP_DIV_SUBNORMAL_EN
  logic signed [EW-1:0] sh;
`endif

  always_comb begin
    rnd_v = quo_q;
    rnd_s = (rem_q != '0);
    tiny  = (e_q < E_ONE);
`ifdef HP_DIV_SUBNORMAL_EN
    sh = E_ONE - e_q;
    if (tiny) begin
      if (sh > SH_MAX) begin
        rnd_v = '0;
        rnd_s = 1'b1;
      end else begin
        rnd_v = quo_q >> sh;
        rnd_s = rnd_s | (|(quo_q & ~({NITER{1'b1}} << sh)));
      end
    end
`endif
    mant    = rnd_v[NITER-1:2];
    g_bit   = rnd_v[1];
    r_bit   = rnd_v[0];
    inexact = g_bit | r_bit | rnd_s;
    up      = g_bit & (r_bit | rnd_s | mant[0]);
    mant_r  = {1'b0, mant} + {{MW{1'b0}}, up};
    carry   = mant_r[MW];
    mant_n  = carry ? mant_r[MW:1] : mant_r[MW-1:0];
    hidden  = mant_n[MW-1];
    e_r     = e_q + {{(EW-1){1'b0}}, carry};

    rnd_q     = {sign_q, e_r[NEXP-1:0], mant_n[NSIG-1:0]};
    rnd_flags = hidden ? F_NORMAL : F_SUBN;
    rnd_exc   = inexact ? X_INX : X_NONE;

    if (tiny) begin
`ifdef HP_DIV_SUBNORMAL_EN
      // A carry into the hidden bit lands exactly on the minimum normal.
      rnd_q     = {sign_q, {(NEXP-1){1'b0}}, hidden, mant_n[NSIG-1:0]};
      rnd_flags = hidden ? F_NORMAL : ((mant_n == '0) ? F_ZERO : F_SUBN);
      rnd_exc   = inexact ? (X_UNF | X_INX) : X_NONE;
`else
      rnd_q     = {sign_q, {(W-1){1'b0}}};
      rnd_flags = F_ZERO;
      rnd_exc   = X_UNF | X_INX;
`endif
    end else if (e_r >= EMAX) begin
      rnd_q     = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
      rnd_flags = F_INF;
      rnd_exc   = X_OVF | X_INX;
    end
  end

  // Control FSM with registered outputs; all state is cleared by reset so an
  // aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      flags_q <= '0;
      exc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          sign_q <= res_sign;
          if (spec_hit) begin
            q_q     <= spec_q;
            flags_q <= spec_flags;
            exc_q   <= spec_exc;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            e_q     <= e_init;
            mb_q    <= mb_n;
            rem_q   <= rem_init;
            quo_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= rem_div_d;
          quo_q <= {quo_q[NITER-2:0], div_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(NITER - 1)) state_q <= S_RND;
        end
        S_RND: begin
          q_q     <= rnd_q;
          flags_q <= rnd_flags;
          exc_q   <= rnd_exc;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_div_seq.sv
// Self-checking bench for hp_div_seq (bfloat16 parameters). Expected results
// are queued when a request is issued and compared when done pulses.
// Expectations follow HP_DIV_SUBNORMAL_EN when it is defined for the build.
module tb_hp_div_seq;

  localparam int NEXP = 8;
  localparam int NSIG = 7;

  localparam logic [5:0] F_NORMAL = 6'b000001;
  localparam logic [5:0] F_SUBN   = 6'b000010;
  localparam logic [5:0] F_ZERO   = 6'b000100;
  localparam logic [5:0] F_INF    = 6'b001000;
  localparam logic [5:0] F_QNAN   = 6'b010000;

  localparam logic [4:0] X_NONE = 5'b00000;
  localparam logic [4:0] X_INV  = 5'b00001;
  localparam logic [4:0] X_DBZ  = 5'b00010;
  localparam logic [4:0] X_OVF  = 5'b00100;
  localparam logic [4:0] X_UNF  = 5'b01000;
  localparam logic [4:0] X_INX  = 5'b10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hp_div_seq_if #(.NEXP(NEXP), .NSIG(NSIG)) bus ();

  hp_div_seq #(.NEXP(NEXP), .NSIG(NSIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [5:0]  flags;
    logic [4:0]  exc;
    logic [7:0]  lat;
  } exp_t;

  exp_t  sb[$];
  string sb_names[$];

  // Queue the expected result and present one request on the start edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [5:0] ef,
                       input logic [4:0] ee, input int elat, input string nm);
    exp_t e;
    e.q = eq; e.flags = ef; e.exc = ee; e.lat = 8'(elat);
    sb.push_back(e);
    sb_names.push_back(nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  // Wait (bounded) for done, then pop and compare the oldest expectation.
  // A nonzero poke_cycle pulses start with other operands in that cycle.
  task automatic collect(input int poke_cycle);
    exp_t  e;
    string nm;
    int    cyc;
    bit    got;
    cyc = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (cyc == poke_cycle) begin
          bus.start = 1'b1;
          bus.a     = 16'h3F80;
          bus.b     = 16'h0000;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    e  = sb.pop_front();
    nm = sb_names.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
    end else begin
      if (bus.q !== e.q) begin
        tests_failed++;
        $display("FAIL %s q: got %h expected %h", nm, bus.q, e.q);
      end
      tests_run++;
      if (bus.bfFlags !== e.flags) begin
        tests_failed++;
        $display("FAIL %s bfFlags: got %b expected %b", nm, bus.bfFlags, e.flags);
      end
      tests_run++;
      if (bus.exception !== e.exc) begin
        tests_failed++;
        $display("FAIL %s exception: got %b expected %b", nm, bus.exception, e.exc);
      end
      tests_run++;
      if (cyc !== int'(e.lat)) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d expected %0d", nm, cyc, e.lat);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset busy/done: got %b expected 00", {bus.busy, bus.done});
    end
    tests_run++;
    if ({bus.q, bus.bfFlags, bus.exception} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset outputs: got q=%h flags=%b exc=%b expected all zero",
               bus.q, bus.bfFlags, bus.exception);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_finite();
    issue(16'h40C0, 16'h4000, 16'h4040, F_NORMAL, X_NONE, 13, "6/2");
    collect(0);
    issue(16'h3F80, 16'h4040, 16'h3EAB, F_NORMAL, X_INX, 13, "1/3");
    collect(0);
    issue(16'hC0C0, 16'h4000, 16'hC040, F_NORMAL, X_NONE, 13, "-6/2");
    collect(0);
    issue(16'h4000, 16'h4040, 16'h3F2B, F_NORMAL, X_INX, 13, "2/3");
    collect(0);
  endtask

  task automatic test_specials();
    issue(16'h3F80, 16'h0000, 16'h7F80, F_INF,  X_DBZ,  2, "1/0");
    collect(0);
    issue(16'h3F80, 16'h8000, 16'hFF80, F_INF,  X_DBZ,  2, "1/-0");
    collect(0);
    issue(16'h0000, 16'h8000, 16'h7FC0, F_QNAN, X_INV,  2, "0/-0");
    collect(0);
    issue(16'h7F81, 16'h3F80, 16'h7FC0, F_QNAN, X_INV,  2, "snan/1");
    collect(0);
    issue(16'h7FC0, 16'h7F81, 16'h7FC0, F_QNAN, X_INV,  2, "qnan/snan");
    collect(0);
    issue(16'hFFC1, 16'h3F80, 16'h7FC0, F_QNAN, X_NONE, 2, "qnan/1");
    collect(0);
    issue(16'h7F80, 16'hFF80, 16'h7FC0, F_QNAN, X_INV,  2, "inf/-inf");
    collect(0);
    issue(16'hFF80, 16'h4000, 16'hFF80, F_INF,  X_NONE, 2, "-inf/2");
    collect(0);
    issue(16'h3F80, 16'h7F80, 16'h0000, F_ZERO, X_NONE, 2, "1/inf");
    collect(0);
    issue(16'h8000, 16'h3F80, 16'h8000, F_ZERO, X_NONE, 2, "-0/1");
    collect(0);
  endtask

  task automatic test_overflow();
    issue(16'h7F7F, 16'h3F00, 16'h7F80, F_INF, X_OVF | X_INX, 13, "max/0.5");
    collect(0);
  endtask

  task automatic test_underflow();
`ifdef HP_DIV_SUBNORMAL_EN
    issue(16'h0080, 16'h4000, 16'h0040, F_SUBN,   X_NONE,        13, "minnorm/2");
    collect(0);
    issue(16'h0080, 16'h4040, 16'h002B, F_SUBN,   X_UNF | X_INX, 13, "minnorm/3");
    collect(0);
    issue(16'h00FF, 16'h4000, 16'h0080, F_NORMAL, X_UNF | X_INX, 13, "round_to_minnorm");
    collect(0);
    issue(16'h0040, 16'h3F80, 16'h0040, F_SUBN,   X_NONE,        13, "subn_in/1");
    collect(0);
    issue(16'h3F80, 16'h0001, 16'h7F80, F_INF,    X_OVF | X_INX, 13, "1/subn_in");
    collect(0);
`else
    issue(16'h0080, 16'h4000, 16'h0000, F_ZERO, X_UNF | X_INX, 13, "minnorm/2");
    collect(0);
    issue(16'h0080, 16'h4040, 16'h0000, F_ZERO, X_UNF | X_INX, 13, "minnorm/3");
    collect(0);
    issue(16'h00FF, 16'h4000, 16'h0000, F_ZERO, X_UNF | X_INX, 13, "round_to_minnorm");
    collect(0);
    issue(16'h0040, 16'h3F80, 16'h0000, F_ZERO, X_NONE,         2, "subn_in/1");
    collect(0);
    issue(16'h3F80, 16'h0001, 16'h7F80, F_INF,  X_DBZ,          2, "1/subn_in");
    collect(0);
`endif
    issue(16'h0080, 16'h7F00, 16'h0000, F_ZERO, X_UNF | X_INX, 13, "deep_underflow");
    collect(0);
  endtask

  task automatic test_start_during_busy();
    int extra_done;
    issue(16'h40C0, 16'h4000, 16'h4040, F_NORMAL, X_NONE, 13, "start_in_div");
    collect(5);
    // Request held across the DONE edge must also be ignored.
    bus.start = 1'b1;
    bus.a     = 16'h3F80;
    bus.b     = 16'h0000;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra_done++;
    end
    tests_run++;
    if (extra_done !== 0) begin
      tests_failed++;
      $display("FAIL ignored_start extra done: got %0d expected 0", extra_done);
    end
    tests_run++;
    if (bus.q !== 16'h4040 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_result: got q=%h busy=%b expected q=4040 busy=0", bus.q, bus.busy);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h3F80;
    bus.b     = 16'h4040;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.q, bus.bfFlags, bus.exception} !== 29'd0) begin
      tests_failed++;
      $display("FAIL abort outputs: got busy=%b done=%b q=%h flags=%b exc=%b expected all zero",
               bus.busy, bus.done, bus.q, bus.bfFlags, bus.exception);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort no_done: got done_count=%0d busy=%b expected 0 and 0",
               seen_done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    issue(16'h3F80, 16'h4040, 16'h3EAB, F_NORMAL, X_INX,  13, "b2b_1/3");
    collect(0);
    issue(16'h40C0, 16'h4000, 16'h4040, F_NORMAL, X_NONE, 13, "b2b_6/2");
    collect(0);
    issue(16'h7F81, 16'h3F80, 16'h7FC0, F_QNAN,   X_INV,   2, "b2b_snan");
    collect(0);
    issue(16'h3F80, 16'h0000, 16'h7F80, F_INF,    X_DBZ,   2, "b2b_1/0");
    collect(0);
  endtask

  initial begin
    test_reset();
    test_finite();
    test_specials();
    test_overflow();
    test_underflow();
    test_start_during_busy();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
